// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating counters, registered next-PC prediction
module branch_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [31:0] req_pc,
   input  logic        flush,
   output logic        pred_valid,
   output logic [31:0] pred_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_is_jump,
   input  logic        upd_taken,
   input  logic [31:0] upd_target
);
   localparam int IDX = $clog2(ENTRIES);
   localparam int TW  = 30 - IDX;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];
   logic               jump_q   [ENTRIES];
   logic               jump_d   [ENTRIES];
   logic [TW-1:0]      tag_q    [ENTRIES];
   logic [TW-1:0]      tag_d    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [31:0]        target_d [ENTRIES];

   logic        pred_valid_q, pred_valid_d;
   logic [31:0] pred_pc_q, pred_pc_d;
   logic        pred_taken_q, pred_taken_d;
   logic [31:0] pred_target_q, pred_target_d;

   logic [IDX-1:0] req_idx, upd_idx;
   logic [TW-1:0]  req_tag, upd_tag;
   logic           req_hit, upd_hit, req_redirect;
   logic           upd_pc_unused;

   assign req_idx = req_pc[IDX+1:2];
   assign req_tag = req_pc[31:IDX+2];
   assign upd_idx = upd_pc[IDX+1:2];
   assign upd_tag = upd_pc[31:IDX+2];
   assign upd_pc_unused = ^upd_pc[1:0];

   assign req_hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign req_redirect = req_hit && (jump_q[req_idx] || ctr_q[req_idx][1]);

   // Lookup reads the _q arrays, so a same-cycle update is not seen (read-before-write).
   always_comb begin
      pred_valid_d  = req_valid && !flush;
      pred_pc_d     = pred_pc_q;
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
      if (req_valid) begin
         pred_pc_d     = req_pc;
         pred_taken_d  = req_redirect;
         pred_target_d = req_redirect ? target_q[req_idx] : req_pc + 32'd4;
      end
   end

   always_comb begin
      valid_d  = valid_q;
      ctr_d    = ctr_q;
      jump_d   = jump_q;
      tag_d    = tag_q;
      target_d = target_q;
      if (upd_valid) begin
         if (upd_hit) begin
            if (upd_is_jump) begin
               ctr_d[upd_idx] = 2'b11;
            end else if (upd_taken && ctr_q[upd_idx] != 2'b11) begin
               ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
            end else if (!upd_taken && ctr_q[upd_idx] != 2'b00) begin
               ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
            end
            if (upd_taken) begin
               target_d[upd_idx] = upd_target;
            end
         end else if (upd_taken) begin
            // Miss with a taken outcome replaces whatever occupied the slot.
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = upd_target;
            jump_d[upd_idx]   = upd_is_jump;
            ctr_d[upd_idx]    = upd_is_jump ? 2'b11 : 2'b10;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= 2'b01;
         end
         pred_valid_q  <= 1'b0;
         pred_pc_q     <= '0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
      end else begin
         valid_q       <= valid_d;
         ctr_q         <= ctr_d;
         pred_valid_q  <= pred_valid_d;
         pred_pc_q     <= pred_pc_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
      end
   end

   // Payload storage is qualified by valid_q, so it carries no reset.
   always_ff @(posedge clk) begin
      jump_q   <= jump_d;
      tag_q    <= tag_d;
      target_q <= target_d;
   end

   assign pred_valid  = pred_valid_q;
   assign pred_pc     = pred_pc_q;
   assign pred_taken  = pred_taken_q;
   assign pred_target = pred_target_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and randomized checks of branch_predictor against a table model
module tb_branch_predictor;
   localparam int ENTRIES = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_pc = '0;
   logic        flush = 1'b0;
   logic        pred_valid;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_is_jump = 1'b0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;

   int n_checks = 0;
   int n_errors = 0;

   bit          m_valid  [ENTRIES];
   int unsigned m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   bit          m_jump   [ENTRIES];
   int          m_ctr    [ENTRIES];

   branch_predictor #(.ENTRIES(ENTRIES)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_pc(req_pc), .flush(flush),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
      .upd_taken(upd_taken), .upd_target(upd_target)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 0;
         m_ctr[i]   = 1;
      end
   endfunction

   // Called at a negedge: applies one cycle of inputs, advances the model, checks after the edge.
   task automatic step(input logic rv, input logic [31:0] rpc, input logic fl,
                       input logic uv, input logic [31:0] upc, input logic uj,
                       input logic ut, input logic [31:0] utgt);
      int          ri, ui;
      int unsigned rt, ut_tag;
      bit          hit, e_taken;
      logic [31:0] e_target;
      req_valid = rv; req_pc = rpc; flush = fl;
      upd_valid = uv; upd_pc = upc; upd_is_jump = uj; upd_taken = ut; upd_target = utgt;
      ri = int'((rpc >> 2) % ENTRIES);
      rt = rpc / (4 * ENTRIES);
      hit = m_valid[ri] && (m_tag[ri] == rt);
      e_taken = hit && (m_jump[ri] || m_ctr[ri] >= 2);
      e_target = e_taken ? m_target[ri] : rpc + 32'd4;
      if (uv) begin
         ui = int'((upc >> 2) % ENTRIES);
         ut_tag = upc / (4 * ENTRIES);
         if (m_valid[ui] && m_tag[ui] == ut_tag) begin
            if (uj) m_ctr[ui] = 3;
            else if (ut) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
            else m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
            if (ut) m_target[ui] = utgt;
         end else if (ut) begin
            m_valid[ui] = 1; m_tag[ui] = ut_tag; m_target[ui] = utgt;
            m_jump[ui] = uj; m_ctr[ui] = uj ? 3 : 2;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("pred_valid", {31'd0, pred_valid}, {31'd0, rv && !fl});
      if (rv && !fl) begin
         check("pred_pc", pred_pc, rpc);
         check("pred_taken", {31'd0, pred_taken}, {31'd0, e_taken});
         check("pred_target", pred_target, e_target);
      end
   endtask

   task automatic req(input logic [31:0] pc);
      step(1'b1, pc, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic upd(input logic [31:0] pc, input logic j, input logic t, input logic [31:0] tgt);
      step(1'b0, '0, 1'b0, 1'b1, pc, j, t, tgt);
   endtask

   task automatic expect_pred(input string tag, input logic t, input logic [31:0] tgt);
      check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
      check({tag, "_target"}, pred_target, tgt);
   endtask

   task automatic mid_reset();
      #3 rst_n = 1'b0;
      #1 check("async_rst_pred_valid", {31'd0, pred_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("rst_pred_pc", pred_pc, 32'd0);
      check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      check("rst_pred_target", pred_target, 32'd0);
      rst_n = 1'b1;

      req(32'h100);                       expect_pred("cold", 1'b0, 32'h104);
      upd(32'h100, 1'b0, 1'b1, 32'h140);
      req(32'h100);                       expect_pred("beq_taken", 1'b1, 32'h140);
      upd(32'h100, 1'b0, 1'b0, 32'h0);
      upd(32'h100, 1'b0, 1'b0, 32'h0);
      req(32'h100);                       expect_pred("ctr_00", 1'b0, 32'h104);
      upd(32'h100, 1'b0, 1'b0, 32'h0);
      upd(32'h100, 1'b0, 1'b1, 32'h140);
      req(32'h100);                       expect_pred("ctr_sat_low", 1'b0, 32'h104);
      upd(32'h100, 1'b0, 1'b1, 32'h140);
      req(32'h100);                       expect_pred("ctr_retrain", 1'b1, 32'h140);

      upd(32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h140, 1'b0, 1'b1, 32'h300);
      req(32'h100);                       expect_pred("alias_evicted", 1'b0, 32'h104);
      req(32'h140);                       expect_pred("alias_new", 1'b1, 32'h300);

      step(1'b1, 32'h180, 1'b0, 1'b1, 32'h180, 1'b0, 1'b1, 32'h1C0);
      expect_pred("rbw_same", 1'b0, 32'h184);
      req(32'h180);                       expect_pred("rbw_next", 1'b1, 32'h1C0);

      req(32'hFFFFFFFC);                  expect_pred("wrap", 1'b0, 32'h0);

      step(1'b1, 32'h180, 1'b1, 1'b1, 32'h208, 1'b1, 1'b1, 32'h400);
      req(32'h208);                       expect_pred("flush_upd_commits", 1'b1, 32'h400);

      mid_reset();
      req(32'h180);                       expect_pred("post_rst", 1'b0, 32'h184);

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] pool [6];
         logic [31:0] rpc, upc, tgt;
         logic        uj, ut;
         pool[0] = 32'h100; pool[1] = 32'h140; pool[2] = 32'h180;
         pool[3] = 32'h204; pool[4] = 32'h13C; pool[5] = 32'hFFFFFFFC;
         rpc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFFFFC) : pool[$urandom_range(0, 5)];
         upc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFFFFC) : pool[$urandom_range(0, 5)];
         tgt = $urandom & 32'hFFFFFFFC;
         uj  = ($urandom_range(0, 3) == 0);
         ut  = uj | ($urandom_range(0, 1) == 1);
         step($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 15) == 0,
              $urandom_range(0, 1) == 1, upc, uj, ut, tgt);
         if (n % 700 == 699) mid_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
